// File: rtl/regfile_dump.sv
// regfile_dump: walks every register through one read port and streams {index, value} beats over valid/ready.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | read port addressed with idx, value captured on the edge
  // SEND  | register beat valid, waiting for handshake
  // CSUM  | checksum beat valid (checksum build only)
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
`ifdef REGDUMP_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    data_d       = data_q;
`ifdef REGDUMP_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    busy         = (state_q != IDLE);
    done         = 1'b0;
    rf_read_addr = '0;
    dump_valid   = 1'b0;
    dump_addr    = '0;
    dump_data    = '0;
    dump_last    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = READ;
        end
      end
      READ: begin
        rf_read_addr = idx_q;
        data_d       = rf_read_data;
        addr_d       = idx_q;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d       = csum_q ^ rf_read_data;
`endif
        state_d      = SEND;
      end
      SEND: begin
        // Beat fields come from flops, so they stay put while the sink stalls.
        rf_read_addr = idx_q;
        dump_valid   = 1'b1;
        dump_addr    = addr_q;
        dump_data    = data_q;
`ifndef REGDUMP_CHECKSUM_EN
        dump_last    = (idx_q == LAST_IDX);
`endif
        if (dump_ready) begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: begin
        dump_valid = 1'b1;
        dump_data  = csum_q;
        dump_last  = 1'b1;
        if (dump_ready) state_d = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a cycle-level beat/timing model checked every cycle, plus directed literal checks.
module tb_regfile_dump;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CSUM_EXTRA = 1;
`else
  localparam int CSUM_EXTRA = 0;
`endif
  localparam int TOTAL = NUM_REGS + CSUM_EXTRA;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy, done;
  logic [ADDR_W-1:0] rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;
  logic              dump_valid, dump_ready, dump_last;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  logic [DATA_W-1:0] regfile [NUM_REGS];
  assign rf_read_data = regfile[rf_read_addr];

  regfile_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_last(dump_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a dump accepted at edge N has "cycle N+k" with k counted from that edge;
  // done lands at k = 65 + stalls (+1 with checksum), and beat i carries regfile[i].
  bit m_active = 0;
  int m_n = 0;
  int m_idx = 0;
  int m_stalls = 0;
  int m_done_count = 0;
  int m_last_done_k = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] xor_all();
    logic [DATA_W-1:0] x = '0;
    for (int i = 0; i < NUM_REGS; i++) x ^= regfile[i];
    return x;
  endfunction

  task automatic compare_cycle();
    int kk, dk;
    logic [DATA_W-1:0] ed;
    logic [ADDR_W-1:0] ea;
    kk = 0;
    dk = 65 + CSUM_EXTRA;
    if (m_active) begin
      kk = cyc - m_n + 1;
      dk = 65 + m_stalls + CSUM_EXTRA;
      if (kk > dk) m_active = 0;
    end
    if (!m_active) begin
      check("idle_outputs",
            {18'd0, busy, done, dump_valid, dump_last, dump_addr, rf_read_addr, dump_data},
            64'd0);
    end else begin
      check("busy", {63'd0, busy}, 64'd1);
      check("done_timing", {63'd0, done}, {63'd0, (kk == dk)});
      if (kk == 1 || kk == dk) check("valid_gap", {63'd0, dump_valid}, 64'd0);
      if (dump_valid) begin
        if (m_idx >= TOTAL) begin
          check("extra_beat", {63'd0, dump_valid}, 64'd0);
        end else begin
          if (m_idx < NUM_REGS) begin
            ed = regfile[m_idx];
            ea = ADDR_W'(m_idx);
            check("rf_read_addr", {59'd0, rf_read_addr}, {59'd0, ea});
          end else begin
            ed = xor_all();
            ea = '0;
          end
          check("beat_addr", {59'd0, dump_addr}, {59'd0, ea});
          check("beat_data", {32'd0, dump_data}, {32'd0, ed});
          check("beat_last", {63'd0, dump_last}, {63'd0, (m_idx == TOTAL - 1)});
        end
      end
      if (done) begin
        check("beat_count", 64'(m_idx), 64'(TOTAL));
        m_done_count++;
        m_last_done_k = kk;
      end
    end
    if (!rst_n) begin
      m_active = 0;
      m_idx = 0;
      m_stalls = 0;
    end else if (m_active) begin
      if (dump_valid && dump_ready) m_idx++;
      else if (dump_valid) m_stalls++;
    end else if (start) begin
      m_active = 1;
      m_n = cyc + 1;
      m_idx = 0;
      m_stalls = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int c0 = m_done_count;
    int n = 0;
    while (m_done_count == c0 && n < max_cyc) begin
      tick();
      n++;
    end
    if (m_done_count == c0) check("done_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic wait_beat(input int addr, input string name);
    int n = 0;
    while (!(dump_valid && dump_addr == ADDR_W'(addr)) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check(name, 64'd0, 64'd1);
  endtask

  initial begin
    int dc;
    int n;
    rst_n = 1'b0;
    start = 1'b1;
    dump_ready = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) regfile[i] = 32'h1000 + i;

    tick();
    tick();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_valid", {63'd0, dump_valid}, 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();

    // Full dump, sink always ready
    pulse_start();
    wait_done(200);
    check("full_done_k", 64'(m_last_done_k), 64'(65 + CSUM_EXTRA));
    check("full_beats", 64'(m_idx), 64'(TOTAL));

    // Three stall cycles on beat 5
    pulse_start();
    wait_beat(5, "bp_wait");
    dump_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_data", {32'd0, dump_data}, 64'h1005);
      check("bp_addr", {59'd0, dump_addr}, 64'd5);
      check("bp_valid", {63'd0, dump_valid}, 64'd1);
    end
    dump_ready = 1'b1;
    wait_done(200);
    check("bp_done_k", 64'(m_last_done_k), 64'(68 + CSUM_EXTRA));

    // Start re-asserted at beats 3 and 20 and during DONE
    dc = m_done_count;
    pulse_start();
    wait_beat(3, "restart_wait3");
    pulse_start();
    wait_beat(20, "restart_wait20");
    pulse_start();
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("restart_saw_done", {63'd0, done}, 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("restart_one_done", 64'(m_done_count), 64'(dc + 1));
    check("restart_idle", {63'd0, busy}, 64'd0);

    // Reset right after beat 10 handshake
    dc = m_done_count;
    pulse_start();
    wait_beat(10, "abort_wait");
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_valid", {63'd0, dump_valid}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("abort_no_done", 64'(m_done_count), 64'(dc));
    pulse_start();
    wait_done(200);
    check("after_abort_k", 64'(m_last_done_k), 64'(65 + CSUM_EXTRA));

    // Index pattern with x5 poisoned, sink stalling every third cycle
    for (int i = 0; i < NUM_REGS; i++) regfile[i] = i;
    regfile[5] = 32'hDEADBEEF;
    pulse_start();
    n = 0;
    while (!(dump_valid && dump_last) && n < 300) begin
      dump_ready = ((n % 3) != 2);
      tick();
      n++;
    end
    dump_ready = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
    check("csum_data", {32'd0, dump_data}, 64'hDEADBEEA);
    check("csum_addr", {59'd0, dump_addr}, 64'd0);
`else
    check("last_data", {32'd0, dump_data}, 64'd31);
    check("last_addr", {59'd0, dump_addr}, 64'd31);
`endif
    check("last_flag", {63'd0, dump_last}, 64'd1);
    wait_done(300);

    // All-zero register file
    for (int i = 0; i < NUM_REGS; i++) regfile[i] = '0;
    pulse_start();
    n = 0;
    while (!(dump_valid && dump_last) && n < 200) begin
      tick();
      n++;
    end
    check("zero_last_data", {32'd0, dump_data}, 64'd0);
    check("zero_last_flag", {63'd0, dump_last}, 64'd1);
    wait_done(200);
    check("zero_done_k", 64'(m_last_done_k), 64'(65 + CSUM_EXTRA));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
